local_memory_stream_reader: RTL

- Drains a contiguous region of a dual-port local memory through its port B and emits the words as an AXI4-Stream master, with TLAST on the final word.
- Sits directly downstream of the local memory. It drives the memory's port-B read controls and consumes its registered 1-cycle-latency read data.
- Controlled by a start/length command from the co-processor control logic. Reports busy/done.

---
 rtl/local_memory_stream_reader_pkg.sv | 17 +
 rtl/stream_fifo2.sv | 58 +++++
 rtl/local_memory_stream_reader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/local_memory_stream_reader_pkg.sv
// ---------------------------------------------------------------------------
// local_memory_stream_reader_pkg
// Shared definitions for the local-memory stream reader and its helpers.
//   STREAM_WIDTH    : width of one stream/memory word
//   reader_state_t  : command FSM states (IDLE, RUN, DRAIN)
// ---------------------------------------------------------------------------
package local_memory_stream_reader_pkg;

    localparam int STREAM_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/stream_fifo2.sv
// ---------------------------------------------------------------------------
// stream_fifo2
// Two-entry registered FIFO for stream stages. The head entry is read
// directly from storage, so it is stable while the FIFO is not popped.
// The caller must never push into a full FIFO unless it pops in the same
// cycle, and must never pop an empty FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the end of this cycle
//   push_data  : entry to write
//   pop        : drop the head entry at the end of this cycle
//   head_data  : oldest entry (meaningful while count != 0)
//   count      : number of stored entries (0..2)
// ---------------------------------------------------------------------------
module stream_fifo2
    import local_memory_stream_reader_pkg::*;
#(
    parameter int WIDTH = STREAM_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = entry[rd_ptr];

endmodule

// File: rtl/local_memory_stream_reader.sv
// ---------------------------------------------------------------------------
// local_memory_stream_reader
// Reads `length` consecutive words of a dual-port local memory through port B
// (starting at `base_addr`, wrapping modulo 2**SIZE_ADDR) and emits them as an
// AXI4-Stream master, with TLAST on the final word.
// Ports:
//   aclk, aresetn          : clock, asynchronous active-low reset
//   start/base_addr/length : command; sampled only while idle
//   busy, done             : command in progress / one-cycle completion pulse
//   rden_b, address_b      : port-B read controls (registered)
//   wren_b, data_in_b      : port-B write controls, never used (tied 0)
//   data_out_b             : port-B read data, 1-cycle latency, held when idle
//   m_axis_*               : AXI4-Stream master output
// ---------------------------------------------------------------------------
module local_memory_stream_reader
    import local_memory_stream_reader_pkg::*;
#(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_MEM  = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [SIZE_ADDR-1:0]    base_addr,
    input  logic [SIZE_ADDR:0]      length,
    output logic                    busy,
    output logic                    done,
    output logic                    rden_b,
    output logic                    wren_b,
    output logic [SIZE_ADDR-1:0]    address_b,
    output logic [STREAM_WIDTH-1:0] data_in_b,
    input  logic [STREAM_WIDTH-1:0] data_out_b,
    output logic [STREAM_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    localparam logic [SIZE_ADDR:0] ONE     = (SIZE_ADDR + 1)'(1);
    localparam logic [SIZE_ADDR:0] MAX_LEN = (SIZE_ADDR + 1)'(SIZE_MEM);

    reader_state_t         state;
    logic [SIZE_ADDR:0]    len_q;
    logic [SIZE_ADDR:0]    issue_cnt;
    logic [SIZE_ADDR:0]    beat_cnt;
    logic [SIZE_ADDR:0]    len_capped;
    logic [SIZE_ADDR-1:0]  next_addr;
    logic                  pending;
    logic [1:0]            fifo_count;
    logic [STREAM_WIDTH:0] fifo_head;
    logic [2:0]            credit;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic                  tlast_in;

    assign wren_b    = 1'b0;
    assign data_in_b = '0;

    assign len_capped = (length > MAX_LEN) ? MAX_LEN : length;

    assign pop = m_axis_tvalid & m_axis_tready;

    // The memory holds its read data while rden_b is low, so a returned word
    // may wait on data_out_b until the FIFO has room.
    assign push = pending & ((fifo_count != 2'd2) | pop);

    // A new read is allowed only if the word it returns is certain to find a
    // free FIFO slot even if the stream stalls from now on; otherwise it would
    // overwrite a still-waiting word on data_out_b.
    assign credit     = {1'b0, fifo_count} + {2'b00, push} - {2'b00, pop};
    assign issue      = (state == ST_RUN) && (issue_cnt != len_q) && (credit < 3'd2);
    assign last_issue = issue && ((issue_cnt + ONE) == len_q);
    assign tlast_in   = (beat_cnt == (len_q - ONE));

    // A word is waiting on data_out_b from the cycle after a read until pushed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pending <= 1'b0;
        end else if (rden_b) begin
            pending <= 1'b1;
        end else if (push) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rden_b    <= 1'b0;
            address_b <= '0;
            next_addr <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            done   <= 1'b0;
            rden_b <= issue;
            if (issue) begin
                address_b <= next_addr;
                next_addr <= next_addr + 1'b1;
                issue_cnt <= issue_cnt + ONE;
            end
            if (push) begin
                beat_cnt <= beat_cnt + ONE;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q     <= len_capped;
                        next_addr <= base_addr;
                        issue_cnt <= '0;
                        beat_cnt  <= '0;
                        busy      <= 1'b1;
                        // An empty command skips straight to completion.
                        state     <= (len_capped == '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_issue) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((len_q == '0) || (pop && m_axis_tlast)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    stream_fifo2 #(
        .WIDTH(STREAM_WIDTH + 1)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (push),
        .push_data ({tlast_in, data_out_b}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign m_axis_tvalid = (fifo_count != 2'd0);
    assign m_axis_tdata  = fifo_head[STREAM_WIDTH-1:0];
    assign m_axis_tlast  = m_axis_tvalid & fifo_head[STREAM_WIDTH];

endmodule
